// File: rtl/checked_counter.sv
// rtl/checked_counter.sv - up/down counter with a self-monitoring "ena_q -> count < LIMIT" property checker
module checked_counter #(
    parameter int WIDTH     = 4,
    parameter int LIMIT     = 5,
    parameter int SATURATE  = 0,
    parameter int ARM_DELAY = 2,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             valid,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_fail_count
);

    localparam int ARM_W = (ARM_DELAY < 1) ? 1 : $clog2(ARM_DELAY + 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAILED   = 2'd2
    } state_t;

    // With no arming delay the monitor is live straight out of reset.
    localparam state_t RESET_STATE = (ARM_DELAY == 0) ? ARMED : DISARMED;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_DELAY);
    localparam logic [32:0]      LIMIT_X  = 33'($unsigned(LIMIT));

    state_t           state;
    state_t           state_n;
    logic [ARM_W-1:0] arm_cnt;
    logic [ARM_W-1:0] arm_n;
    logic [ERR_W-1:0] err_n;
    logic [WIDTH-1:0] ffc_n;
    logic             ena_q;
    logic             in_bound;

    // Counter datapath: load beats ena, ena beats hold; wrap flags only a genuine end-of-range rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            wrap  <= 1'b0;
        end else if (ena && up) begin
            if (count == CNT_MAX) begin
                count <= (SATURATE != 0) ? CNT_MAX : '0;
                wrap  <= (SATURATE == 0);
            end else begin
                count <= count + 1'b1;
                wrap  <= 1'b0;
            end
        end else if (ena) begin
            if (count == '0) begin
                count <= (SATURATE != 0) ? '0 : CNT_MAX;
                wrap  <= (SATURATE == 0);
            end else begin
                count <= count - 1'b1;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // Remember whether the previous cycle counted; the property's antecedent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ena_q <= 1'b0;
        else        ena_q <= ena;
    end

    // Widened compare so a LIMIT beyond the count range is simply always satisfied.
    assign in_bound   = {{(33 - WIDTH){1'b0}}, count} < LIMIT_X;
    assign valid      = (state == DISARMED) || !ena_q || in_bound;
    assign err_sticky = (state == FAILED);

    // Monitor state and its capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= RESET_STATE;
            arm_cnt          <= '0;
            err_cnt          <= '0;
            first_fail_count <= '0;
        end else begin
            state            <= state_n;
            arm_cnt          <= arm_n;
            err_cnt          <= err_n;
            first_fail_count <= ffc_n;
        end
    end

    // Monitor next-state: a failure coincident with clr_err restarts the record instead of being dropped.
    always_comb begin
        state_n = state;
        arm_n   = arm_cnt;
        err_n   = err_cnt;
        ffc_n   = first_fail_count;
        case (state)
            DISARMED: begin
                arm_n = arm_cnt + 1'b1;
                if (arm_n == ARM_LAST) state_n = ARMED;
            end
            ARMED: begin
                if (!valid) begin
                    state_n = FAILED;
                    err_n   = ERR_ONE;
                    ffc_n   = count;
                end
            end
            FAILED: begin
                if (!valid) begin
                    if (clr_err) begin
                        err_n = ERR_ONE;
                        ffc_n = count;
                    end else if (err_cnt != ERR_MAX) begin
                        err_n = err_cnt + 1'b1;
                    end
                end else if (clr_err) begin
                    state_n = ARMED;
                    err_n   = '0;
                    ffc_n   = '0;
                end
            end
            default: state_n = RESET_STATE;
        endcase
    end

endmodule

// File: doc/checked_counter.md
CHECKED_COUNTER -- requirements
Module: checked_counter

Interface
REQ-001 Parameter WIDTH, default 4: count width in bits, legal range 2..32.
REQ-002 Parameter LIMIT, default 5: property bound; the property is "ena in previous cycle -> count < LIMIT".
REQ-003 Parameter SATURATE, default 0: 0 = count wraps at the ends of its range, 1 = count holds at the ends of its range.
REQ-004 Parameter ARM_DELAY, default 2: number of clock cycles after reset release before the monitor arms.
REQ-005 Parameter ERR_W, default 8: width of the error counter.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 ena  in  1  count enable.
REQ-009 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-010 load  in  1  synchronous load of load_val; takes priority over ena.
REQ-011 load_val  in  WIDTH  value to load.
REQ-012 clr_err  in  1  clears the error state.
REQ-013 count  out  WIDTH  counter value (registered).
REQ-014 wrap  out  1  registered pulse, high for the cycle in which count holds a wrapped value.
REQ-015 valid  out  1  combinational property result.
REQ-016 err_sticky  out  1  high while the monitor is in FAILED.
REQ-017 err_cnt  out  ERR_W  count of property failures; saturates at all-ones.
REQ-018 first_fail_count  out  WIDTH  value of count at the first failure.

Function
REQ-019 Counter priority on each edge is load, then ena, then hold.
- load: count <= load_val, wrap <= 0.
REQ-020 When ena=1 and up=1:
- SATURATE=0: count <= count+1 mod 2^WIDTH; wrap <= 1 only on the max->0 transition.
- SATURATE=1: count holds at 2^WIDTH-1; wrap <= 0.
REQ-021 When ena=1 and up=0:
- SATURATE=0: count <= count-1; the 0->max transition sets wrap <= 1.
- SATURATE=1: count holds at 0; wrap <= 0.
REQ-022 ena_q is a register that captures ena every cycle.
REQ-023 valid = (state==DISARMED) || !ena_q || (count < LIMIT).
- The compare is unsigned.
- If LIMIT > 2^WIDTH-1 the compare is always true.
REQ-024 The monitor FSM has three states:
- DISARMED: an arm counter increments each cycle; go to ARMED when it reaches ARM_DELAY. With ARM_DELAY=0, reset enters ARMED directly.
- ARMED: a failure (valid=0 at the edge) goes to FAILED, sets err_cnt=1 and captures first_fail_count=count.
- FAILED: each further failure increments err_cnt (saturating); first_fail_count is unchanged; clr_err returns to ARMED and clears err_cnt and first_fail_count.
REQ-025 When clr_err and a failure occur on the same edge in FAILED:
- The state stays FAILED.
- err_cnt <= 1.
- first_fail_count <= current count.
- No failure is lost.
REQ-026 clr_err in DISARMED or ARMED has no effect.
REQ-027 The monitor never influences counter behaviour.

Reset
REQ-028 While rst_n=0, all of the following hold immediately, independent of clk:
- count=0, wrap=0, ena_q=0, err_sticky=0, err_cnt=0, first_fail_count=0.
- Arm counter=0; state=DISARMED (ARMED if ARM_DELAY=0).
- valid=1.
REQ-029 Reset asserted mid-operation aborts any count, load or failure capture in progress.
REQ-030 Normal operation resumes on the first rising edge after rst_n rises.

Verification (WIDTH=4, LIMIT=5, ARM_DELAY=2, ERR_W=8, SATURATE=0 unless stated)
REQ-031 Reset test: assert rst_n=0 mid-count at count=9 -> count=0, valid=1, err_sticky=0 with no clock edge needed.
REQ-032 Failure test: after reset hold ena=0 for 2 cycles, then ena=1, up=1.
- When count=5 with ena_q=1: valid=0.
- Next edge: err_sticky=1, err_cnt=1, first_fail_count=5.
- Edge after that: err_cnt=2.
REQ-033 Wrap test:
- load_val=15, load=1, then ena=1, up=1 -> count=0 with wrap=1 for one cycle.
- load 0, then up=0 -> count=15 with wrap=1.
- With SATURATE=1, both cases hold the value and wrap stays 0.
REQ-034 Clear test:
- In FAILED, clr_err=1 with ena=0 and ena_q=0 -> ARMED, err_sticky=0, err_cnt=0, first_fail_count=0.
- In FAILED, clr_err=1 coincident with valid=0 at count=7 -> err_sticky=1, err_cnt=1, first_fail_count=7.
REQ-035 Priority and arming test:
- load=1 and ena=1 with load_val=3 -> count=3.
- A failure condition during the 2 DISARMED cycles -> valid=1, err_cnt stays 0.
REQ-036 Saturation test: with ERR_W=2, 5 consecutive failures -> err_cnt=3 (all-ones) and remains 3.
